// File: rtl/atom_npu_seq.sv
// Batch sequencer: buffers (input, weight) pairs, issues them to the NPU core one at a time,
// and returns the saturated sum of the core results on a valid/ready port.
module atom_npu_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DW      = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_input,
  input  logic [DW-1:0]              wr_weight,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       go,
  output logic                       busy,
  output logic                       core_start,
  output logic [DW-1:0]              core_input,
  output logic [DW-1:0]              core_weight,
  input  logic [DW-1:0]              core_output,
  input  logic                       core_done,
  output logic                       res_valid,
  output logic [ACC_W-1:0]           res_data,
  input  logic                       res_ready,
  output logic                       err_timeout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              err_q, err_d;
  logic              full_q, busy_q, start_q, valid_q;
  logic [DW-1:0]     cin_q, cwt_q, head_in, head_wt;
  logic [ACC_W-1:0]  rdata_q;
  logic [DW-1:0]     mem_in_q [DEPTH];
  logic [DW-1:0]     mem_wt_q [DEPTH];
  logic              wr_accept;
  logic [SW-1:0]     sum;

  assign wr_accept = (state_q == IDLE) && wr_en && (count_q != CW'(DEPTH));
  assign sum       = {1'b0, acc_q} + SW'(core_output);

  // Next-state, buffer pointers and accumulator
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (go && (count_d != '0)) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          acc_d    = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
          state_d  = (count_d != '0) ? ISSUE : RESULT;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          count_d  = '0;
          rd_ptr_d = wr_ptr_q;
          state_d  = RESULT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head of the batch; bypass covers a write landing in an empty buffer alongside go
  always_comb begin
    head_in = mem_in_q[rd_ptr_d];
    head_wt = mem_wt_q[rd_ptr_d];
    if (wr_accept && (count_q == '0)) begin
      head_in = wr_input;
      head_wt = wr_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      cin_q    <= '0;
      cwt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      full_q   <= (count_d == CW'(DEPTH));
      busy_q   <= (state_d != IDLE);
      start_q  <= (state_d == ISSUE);
      valid_q  <= (state_d == RESULT);
      if (state_d == ISSUE) begin
        cin_q <= head_in;
        cwt_q <= head_wt;
      end
      if (state_d == RESULT) rdata_q <= acc_d;
    end
  end

  // Pair storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_in_q[i] <= '0;
        mem_wt_q[i] <= '0;
      end
    end else if (wr_accept) begin
      mem_in_q[wr_ptr_q] <= wr_input;
      mem_wt_q[wr_ptr_q] <= wr_weight;
    end
  end

  assign full        = full_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign core_start  = start_q;
  assign core_input  = cin_q;
  assign core_weight = cwt_q;
  assign res_valid   = valid_q;
  assign res_data    = rdata_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_atom_npu_seq.sv
// Directed bench for atom_npu_seq: a core model answers start pulses, a scoreboard holds
// expected sums (8-bit and 5-bit saturating instances run in lockstep).
module tb_atom_npu_seq;

  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, go, res_ready;
  logic [3:0] wr_input, wr_weight, model_out;
  logic       model_done, spur_done, core_done;
  logic       full, busy, core_start, res_valid, err_timeout;
  logic [2:0] count;
  logic [3:0] core_input, core_weight;
  logic [7:0] res_data;
  logic       s_full, s_busy, s_start, s_valid, s_err;
  logic [2:0] s_count;
  logic [3:0] s_cin, s_cwt;
  logic [4:0] s_data;

  int nchk = 0;
  int nerr = 0;
  int exp_q[$];
  logic [7:0] pair_q[$];
  int core_vals[$];
  int core_force = 0;
  int core_lat = 2;
  bit core_mute = 1'b0;
  int nstart = 0;

  assign core_done = model_done | spur_done;

  always #5 clk = ~clk;

  atom_npu_seq #(.DEPTH(4), .DW(4), .ACC_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_input(wr_input), .wr_weight(wr_weight),
    .full(full), .count(count), .go(go), .busy(busy), .core_start(core_start),
    .core_input(core_input), .core_weight(core_weight), .core_output(model_out),
    .core_done(core_done), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .err_timeout(err_timeout));

  atom_npu_seq #(.DEPTH(4), .DW(4), .ACC_W(5), .TIMEOUT(TIMEOUT)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_input(wr_input), .wr_weight(wr_weight),
    .full(s_full), .count(s_count), .go(go), .busy(s_busy), .core_start(s_start),
    .core_input(s_cin), .core_weight(s_cwt), .core_output(model_out),
    .core_done(core_done), .res_valid(s_valid), .res_data(s_data),
    .res_ready(res_ready), .err_timeout(s_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Core model: answers each start after core_lat cycles
  initial begin
    model_done = 1'b0;
    model_out  = '0;
    @(negedge clk);
    forever begin
      if (rst_n && core_start && !core_mute) begin
        repeat (core_lat) @(negedge clk);
        model_out  = 4'((core_vals.size() > 0) ? core_vals.pop_front() : core_force);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Every start pulse must carry the next accepted pair
  always @(negedge clk) begin
    if (core_start) begin
      nstart++;
      if (pair_q.size() == 0) chk("unexpected_start", 32'(core_start), 32'd0);
      else chk("issued_pair", 32'({core_input, core_weight}), 32'(pair_q.pop_front()));
    end
  end

  task automatic push(input logic [3:0] i, input logic [3:0] w, input bit accept);
    wr_input = i; wr_weight = w; wr_en = 1'b1;
    if (accept) pair_q.push_back({i, w});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_go(input int sum, input bit track);
    if (track) exp_q.push_back(sum);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_result(input bit hs);
    int n = 0;
    int e;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    if (!res_valid) begin
      chk("res_valid_wait", 32'(res_valid), 32'd1);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("res_data", 32'(res_data), 32'((e > 255) ? 255 : e));
      chk("res_data_sat5", 32'(s_data), 32'((e > 31) ? 31 : e));
      if (hs) begin
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int s0, n;
    rst_n = 1'b0; wr_en = 1'b0; go = 1'b0; res_ready = 1'b0; spur_done = 1'b0;
    wr_input = '0; wr_weight = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({full, count, busy, core_start, core_input, core_weight,
                            res_valid, res_data, err_timeout}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-pair batch with scripted core results
    push(4'd3, 4'd2, 1'b1); push(4'd1, 4'd1, 1'b1); push(4'd5, 4'd0, 1'b1);
    chk("count3", 32'(count), 32'd3);
    core_vals = '{6, 1, 0};
    s0 = nstart;
    do_go(7, 1'b1);
    chk("start_after_go", 32'(core_start), 32'd1);
    chk("busy_after_go", 32'(busy), 32'd1);
    wait_result(1'b1);
    chk("starts3", 32'(nstart - s0), 32'd3);
    chk("count_after1", 32'(count), 32'd0);
    chk("idle_after1", 32'(busy), 32'd0);

    // Full buffer; fifth write dropped
    for (int k = 0; k < 4; k++) push(4'(k + 1), 4'(k + 8), 1'b1);
    chk("full", 32'(full), 32'd1);
    push(4'd15, 4'd15, 1'b0);
    chk("count_full", 32'(count), 32'd4);
    core_force = 2;
    s0 = nstart;
    do_go(8, 1'b1);
    wait_result(1'b1);
    chk("starts4", 32'(nstart - s0), 32'd4);
    chk("full_clear", 32'(full), 32'd0);

    // Repeated max-value batches: 60 unsaturated, 31 in the 5-bit instance
    core_force = 15;
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 4; k++) push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      do_go(60, 1'b1);
      wait_result(1'b1);
    end

    // Core never answers: timeout after TIMEOUT wait cycles
    core_mute = 1'b1;
    push(4'd7, 4'd7, 1'b1); push(4'd6, 4'd6, 1'b1);
    do_go(0, 1'b1);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("err_timeout", 32'(err_timeout), 32'd1);
    chk("count_flushed", 32'(count), 32'd0);
    wait_result(1'b1);
    pair_q.delete();
    core_mute = 1'b0;
    core_force = 3;
    push(4'd2, 4'd4, 1'b1);
    do_go(3, 1'b1);
    chk("err_cleared", 32'(err_timeout), 32'd0);
    wait_result(1'b1);

    // Result held under back-pressure; go/wr_en ignored meanwhile
    core_force = 9;
    push(4'd1, 4'd2, 1'b1);
    do_go(9, 1'b1);
    wait_result(1'b0);
    go = 1'b1;
    wr_en = 1'b1; wr_input = 4'd5; wr_weight = 4'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'd9);
    end
    go = 1'b0; wr_en = 1'b0;
    chk("hold_count", 32'(count), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("back_idle", 32'({busy, res_valid}), 32'd0);
    @(negedge clk);
    chk("no_restart", 32'({busy, core_start}), 32'd0);

    // Reset mid-wait, then a stray done
    core_mute = 1'b1;
    push(4'd3, 4'd3, 1'b1); push(4'd4, 4'd4, 1'b1);
    do_go(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({busy, core_start, res_valid, count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pair_q.delete();
    core_mute = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy, core_start, res_valid, count, err_timeout}), 32'd0);

    // Write and go in the same cycle on an empty buffer
    core_force = 4;
    exp_q.push_back(4);
    pair_q.push_back({4'd9, 4'd1});
    wr_input = 4'd9; wr_weight = 4'd1; wr_en = 1'b1; go = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; go = 1'b0;
    chk("same_cycle_start", 32'(core_start), 32'd1);
    wait_result(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
